// File: rtl/ahb_txn_arbiter.sv
// ahb_txn_arbiter: round-robin share of one AHB master port with in-order read-tag routing
module ahb_txn_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic                        i_clk_ahb,
    input  logic                        i_rst_ahb,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ-1:0]          i_req_rd0_wr1,
    input  logic [NUM_REQ*ADDR_W-1:0]   i_req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_wr_data,
    output logic [NUM_REQ-1:0]          o_req_ready,
    output logic [NUM_REQ-1:0]          o_req_rd_valid,
    output logic [DATA_W-1:0]           o_req_rd_data,
    output logic                        o_m_valid,
    output logic                        o_m_rd0_wr1,
    output logic [ADDR_W-1:0]           o_m_addr,
    output logic [DATA_W-1:0]           o_m_wr_data,
    input  logic                        i_m_ready,
    input  logic                        i_m_rd_valid,
    input  logic [DATA_W-1:0]           i_m_rd_data,
    output logic [$clog2(NUM_REQ)-1:0]  o_grant_id,
    output logic                        o_busy,
    output logic                        o_err_orphan
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int PW = $clog2(TAG_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state, state_nx;
    logic [GW-1:0] grant, rr_ptr, winner, idx;
    logic [GW-1:0] tag_mem [TAG_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          any_req, full, empty, sel_rd, m_valid, accept, push, pop, orphan;

    assign any_req      = |i_req_valid;
    assign full         = count == CW'(TAG_DEPTH);
    assign empty        = count == '0;
    assign sel_rd       = ~i_req_rd0_wr1[grant];
    // a read may not issue while the tag FIFO is full, even if a pop lands this cycle
    assign m_valid      = (state == ISSUE) && i_req_valid[grant] && !(sel_rd && full);
    assign accept       = m_valid && i_m_ready;
    assign push         = accept && sel_rd;
    assign pop          = i_m_rd_valid && !empty;
    assign o_grant_id   = grant;
    assign o_busy       = (state == ISSUE) || !empty;
    assign o_err_orphan = orphan;

    // round-robin winner: first set valid at or above rr_ptr, wrapping
    always_comb begin
        winner = rr_ptr;
        idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = GW'((int'(rr_ptr) + i) % NUM_REQ);
            if (i_req_valid[idx]) winner = idx;
        end
    end

    // FSM state register
    always_ff @(posedge i_clk_ahb) begin
        if (i_rst_ahb) state <= IDLE;
        else           state <= state_nx;
    end

    // FSM next state and master-side outputs muxed from the grant holder
    always_comb begin
        state_nx    = state;
        o_m_valid   = 1'b0;
        o_m_rd0_wr1 = 1'b0;
        o_m_addr    = '0;
        o_m_wr_data = '0;
        o_req_ready = '0;
        case (state)
            IDLE: if (any_req) state_nx = ISSUE;
            ISSUE: begin
                o_m_valid          = m_valid;
                o_m_rd0_wr1        = i_req_rd0_wr1[grant];
                o_m_addr           = i_req_addr[int'(grant)*ADDR_W +: ADDR_W];
                o_m_wr_data        = i_req_wr_data[int'(grant)*DATA_W +: DATA_W];
                o_req_ready[grant] = accept;
                if (accept || !i_req_valid[grant]) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // grant latches the winner on leaving IDLE; rr_ptr advances only on accept
    always_ff @(posedge i_clk_ahb) begin
        if (i_rst_ahb) begin
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            if (state == IDLE && any_req) grant <= winner;
            if (accept) rr_ptr <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
        end
    end

    // tag FIFO pointers, occupancy and sticky orphan flag
    always_ff @(posedge i_clk_ahb) begin
        if (i_rst_ahb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            orphan <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (i_m_rd_valid && empty) orphan <= 1'b1;
        end
    end

    // tag storage needs no reset; occupancy decides what is valid
    always_ff @(posedge i_clk_ahb) begin
        if (push) tag_mem[wr_ptr] <= grant;
    end

    // read data goes back to the oldest outstanding reader
    always_comb begin
        o_req_rd_valid = '0;
        o_req_rd_data  = '0;
        if (pop) begin
            o_req_rd_valid[tag_mem[rd_ptr]] = 1'b1;
            o_req_rd_data                   = i_m_rd_data;
        end
    end
endmodule

// File: tb/tb_ahb_txn_arbiter.sv
// tb_ahb_txn_arbiter: table-driven plus directed checks of the round-robin AHB arbiter
module tb_ahb_txn_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0, req_rw = '0;
    logic [127:0] req_addr, req_wdata;
    logic [3:0]  req_ready, req_rd_valid;
    logic [31:0] req_rd_data;
    logic        m_valid, m_rw, m_ready = 1'b0, m_rd_valid = 1'b0;
    logic [31:0] m_addr, m_wdata, m_rd_data = '0;
    logic [1:0]  grant_id;
    logic        busy, err_orphan;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    ahb_txn_arbiter dut (
        .i_clk_ahb(clk), .i_rst_ahb(rst),
        .i_req_valid(req_valid), .i_req_rd0_wr1(req_rw),
        .i_req_addr(req_addr), .i_req_wr_data(req_wdata),
        .o_req_ready(req_ready), .o_req_rd_valid(req_rd_valid), .o_req_rd_data(req_rd_data),
        .o_m_valid(m_valid), .o_m_rd0_wr1(m_rw), .o_m_addr(m_addr), .o_m_wr_data(m_wdata),
        .i_m_ready(m_ready), .i_m_rd_valid(m_rd_valid), .i_m_rd_data(m_rd_data),
        .o_grant_id(grant_id), .o_busy(busy), .o_err_orphan(err_orphan)
    );

    typedef struct {
        logic [3:0]  v, rw;
        logic        mr, mrv;
        logic [31:0] mrd;
        logic        e_mv;
        logic [3:0]  e_rdy, e_rdv;
        logic [1:0]  e_g;
        logic        e_busy, e_orph;
        logic [31:0] e_rdd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] v, rw, logic mr, mrv, logic [31:0] mrd,
                                logic e_mv, logic [3:0] e_rdy, e_rdv, logic [1:0] e_g,
                                logic e_busy, e_orph, logic [31:0] e_rdd);
        vec_t r;
        r.v = v; r.rw = rw; r.mr = mr; r.mrv = mrv; r.mrd = mrd;
        r.e_mv = e_mv; r.e_rdy = e_rdy; r.e_rdv = e_rdv; r.e_g = e_g;
        r.e_busy = e_busy; r.e_orph = e_orph; r.e_rdd = e_rdd;
        return r;
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, a, e);
        end
    endtask

    task automatic cyc(input logic [3:0] v, rw, input logic mr, mrv, input logic [31:0] mrd);
        @(negedge clk);
        req_valid = v; req_rw = rw; m_ready = mr; m_rd_valid = mrv; m_rd_data = mrd;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = '0; req_rw = '0; m_ready = 1'b0; m_rd_valid = 1'b0; m_rd_data = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            req_addr[k*32 +: 32]  = 32'h1000_0000 + 32'(k) * 32'h40;
            req_wdata[k*32 +: 32] = 32'h0101_0101 * 32'(k + 1);
        end
        req_wdata[32 +: 32] = 32'hDEAD_BEEF;

        // fairness with all writers, then read routing, then orphan
        for (int c = 0; c < 12; c++)
            tbl.push_back(mk(4'hF, 4'hF, 1, 0, 0, c[0], c[0] ? 4'(1 << ((c / 2) % 4)) : 4'h0,
                             4'h0, 2'((c - 1) / 2 % 4), c[0], 0, 0));
        tbl[0].e_g = 2'd0;
        tbl.push_back(mk(4'h0, 4'h0, 1, 0, 0,            0, 4'h0, 4'h0, 2'd1, 0, 0, 0));
        tbl.push_back(mk(4'h4, 4'h0, 1, 0, 0,            0, 4'h0, 4'h0, 2'd1, 0, 0, 0));
        tbl.push_back(mk(4'h4, 4'h0, 1, 0, 0,            1, 4'h4, 4'h0, 2'd2, 1, 0, 0));
        tbl.push_back(mk(4'h1, 4'h0, 1, 0, 0,            0, 4'h0, 4'h0, 2'd2, 1, 0, 0));
        tbl.push_back(mk(4'h1, 4'h0, 1, 0, 0,            1, 4'h1, 4'h0, 2'd0, 1, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 1, 1, 32'h1111_1111, 0, 4'h0, 4'h4, 2'd0, 1, 0, 32'h1111_1111));
        tbl.push_back(mk(4'h0, 4'h0, 1, 1, 32'h2222_2222, 0, 4'h0, 4'h1, 2'd0, 1, 0, 32'h2222_2222));
        tbl.push_back(mk(4'h0, 4'h0, 1, 0, 32'h5555_5555, 0, 4'h0, 4'h0, 2'd0, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 1, 1, 32'h3333_3333, 0, 4'h0, 4'h0, 2'd0, 0, 0, 0));
        tbl.push_back(mk(4'h0, 4'h0, 1, 0, 0,            0, 4'h0, 4'h0, 2'd0, 0, 1, 0));

        // reset then idle
        do_reset();
        for (int c = 0; c < 10; c++) begin
            cyc(4'h0, 4'h0, 1'b1, 1'b0, '0);
            chk("idle_mvalid", 32'(m_valid), 0);
            chk("idle_ready", 32'(req_ready), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_orphan", 32'(err_orphan), 0);
        end
        chk("idle_grant", 32'(grant_id), 0);
        chk("idle_addr", m_addr, 0);
        chk("idle_rdv", 32'(req_rd_valid), 0);

        // table
        do_reset();
        foreach (tbl[i]) begin
            cyc(tbl[i].v, tbl[i].rw, tbl[i].mr, tbl[i].mrv, tbl[i].mrd);
            chk($sformatf("t%0d_mvalid", i), 32'(m_valid), 32'(tbl[i].e_mv));
            chk($sformatf("t%0d_ready", i), 32'(req_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("t%0d_rdvalid", i), 32'(req_rd_valid), 32'(tbl[i].e_rdv));
            chk($sformatf("t%0d_rddata", i), req_rd_data, tbl[i].e_rdd);
            chk($sformatf("t%0d_grant", i), 32'(grant_id), 32'(tbl[i].e_g));
            chk($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("t%0d_orphan", i), 32'(err_orphan), 32'(tbl[i].e_orph));
        end

        // single write payload, then abandon by req3 leaves rr_ptr at 2
        do_reset();
        cyc(4'h2, 4'h2, 1'b1, 1'b0, '0);
        chk("wr_c0_mvalid", 32'(m_valid), 0);
        cyc(4'h2, 4'h2, 1'b1, 1'b0, '0);
        chk("wr_c1_mvalid", 32'(m_valid), 1);
        chk("wr_c1_addr", m_addr, 32'h1000_0040);
        chk("wr_c1_data", m_wdata, 32'hDEAD_BEEF);
        chk("wr_c1_dir", 32'(m_rw), 1);
        chk("wr_c1_ready", 32'(req_ready), 32'h2);
        cyc(4'h8, 4'h8, 1'b0, 1'b0, '0);
        chk("wr_no_tag_busy", 32'(busy), 0);
        cyc(4'h8, 4'h8, 1'b0, 1'b0, '0);
        chk("ab_issue_mvalid", 32'(m_valid), 1);
        chk("ab_issue_grant", 32'(grant_id), 3);
        chk("ab_issue_ready", 32'(req_ready), 0);
        chk("ab_issue_addr", m_addr, 32'h1000_00C0);
        cyc(4'h0, 4'h8, 1'b0, 1'b0, '0);
        chk("ab_drop_mvalid", 32'(m_valid), 0);
        cyc(4'hF, 4'hF, 1'b0, 1'b0, '0);
        chk("ab_idle_busy", 32'(busy), 0);
        chk("ab_idle_mvalid", 32'(m_valid), 0);
        cyc(4'hF, 4'hF, 1'b0, 1'b0, '0);
        chk("ab_rr_grant", 32'(grant_id), 2);

        // tag FIFO full stalls the fifth read until a return, then it issues
        do_reset();
        for (int c = 0; c < 9; c++) begin
            cyc(4'h1, 4'h0, 1'b1, 1'b0, '0);
            if (c[0]) chk($sformatf("full_rd%0d_ready", c / 2), 32'(req_ready), 1);
        end
        chk("full_stall_mvalid", 32'(m_valid), 0);
        chk("full_stall_ready", 32'(req_ready), 0);
        for (int c = 0; c < 3; c++) begin
            cyc(4'h1, 4'h0, 1'b1, 1'b0, '0);
            chk("full_hold_mvalid", 32'(m_valid), 0);
            chk("full_hold_busy", 32'(busy), 1);
        end
        cyc(4'h1, 4'h0, 1'b1, 1'b1, 32'h0000_00AA);
        chk("full_pop_mvalid", 32'(m_valid), 0);
        chk("full_pop_rdv", 32'(req_rd_valid), 1);
        chk("full_pop_rdd", req_rd_data, 32'h0000_00AA);
        cyc(4'h1, 4'h0, 1'b1, 1'b0, '0);
        chk("full_after_mvalid", 32'(m_valid), 1);
        chk("full_after_ready", 32'(req_ready), 1);

        // reset while in ISSUE clears FIFO, orphan and grant
        do_reset();
        cyc(4'h1, 4'h0, 1'b1, 1'b1, 32'h0000_0077);
        chk("rst_orph_rdv", 32'(req_rd_valid), 0);
        cyc(4'h1, 4'h0, 1'b1, 1'b0, '0);
        chk("rst_orph_set", 32'(err_orphan), 1);
        chk("rst_push_ready", 32'(req_ready), 1);
        cyc(4'h2, 4'h2, 1'b0, 1'b0, '0);
        cyc(4'h2, 4'h2, 1'b0, 1'b0, '0);
        chk("rst_pre_mvalid", 32'(m_valid), 1);
        chk("rst_pre_busy", 32'(busy), 1);
        chk("rst_pre_grant", 32'(grant_id), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_mvalid", 32'(m_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_orphan", 32'(err_orphan), 0);
        chk("rst_grant", 32'(grant_id), 0);
        cyc(4'h0, 4'h0, 1'b0, 1'b1, 32'h0000_0099);
        chk("rst_fifo_empty_rdv", 32'(req_rd_valid), 0);
        cyc(4'h0, 4'h0, 1'b0, 1'b0, '0);
        chk("rst_fifo_empty_orph", 32'(err_orphan), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
